// File: rtl/arp_if.sv
// Arpeggiator scheduler bus: key/config inputs toward the scheduler, note-select outputs back.
interface arp_if #(
    parameter int unsigned DWELL_W = 20
);
    logic [11:0]        keys;
    logic [3:0]         octave_in;
    logic               enable;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         note;
    logic [3:0]         octave;
    logic               note_valid;
    logic               step;

    modport master (
        output keys, octave_in, enable, dwell,
        input  note, octave, note_valid, step
    );

    modport slave (
        input  keys, octave_in, enable, dwell,
        output note, octave, note_valid, step
    );
endinterface

// File: rtl/arp_scheduler.sv
// Arpeggiator scheduler: time-shares one voice across all held keys in pitch order,
// with a per-note dwell time and optional silent gap between notes.
// Optional feature: define ARP_PINGPONG_EN for up/down (ping-pong) traversal;
// undefined gives up-only traversal with wrap.
module arp_scheduler #(
    parameter int unsigned DWELL_W    = 20,
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic  clk,
    input logic  rst_n,
    arp_if.slave bus
);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0]  SILENT   = 4'hF;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t             state_q, state_d;
    logic [11:0]        key_q;
    logic [11:0]        held;
    logic [3:0]         cur_q, cur_d;
    logic [3:0]         note_q, note_d;
    logic [3:0]         octave_q, octave_d;
    logic               valid_q, valid_d;
    logic               step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DWELL_W-1:0] dwell_eff;
    logic [3:0]         sel_note;
    logic [3:0]         start_note;
    logic               start;
    logic [4:0]         up_hit;
`ifdef ARP_PINGPONG_EN
    logic               dir_q, dir_d;
    logic               sel_dir;
    logic [4:0]         dn_hit;
`endif

    // Smallest held note strictly above cur; bit 4 flags a hit.
    function automatic logic [4:0] first_above(input logic [11:0] h, input logic [3:0] cur);
        logic [4:0] res;
        res = '0;
        for (int i = 11; i >= 0; i--) begin
            if (h[i] && (4'(i) > cur)) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

    // Largest held note strictly below cur; bit 4 flags a hit.
    function automatic logic [4:0] first_below(input logic [11:0] h, input logic [3:0] cur);
        logic [4:0] res;
        res = '0;
        for (int i = 0; i < 12; i++) begin
            if (h[i] && (4'(i) < cur)) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

    // Lowest held note number (0 if nothing held).
    function automatic logic [3:0] lowest_held(input logic [11:0] h);
        logic [3:0] res;
        res = '0;
        for (int i = 11; i >= 0; i--) begin
            if (h[i]) res = 4'(i);
        end
        return res;
    endfunction

    // Held-note mask indexed by note number (key bit 11 is note 0).
    always_comb begin
        held = '0;
        for (int n = 0; n < 12; n++) held[n] = key_q[11 - n];
    end

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : DWELL_W'(bus.dwell);

    // Next-note choice from the current note and the registered key set.
    always_comb begin
        up_hit = first_above(held, cur_q);
`ifdef ARP_PINGPONG_EN
        dn_hit  = first_below(held, cur_q);
        sel_dir = dir_q;
        sel_note = cur_q;
        if (!dir_q) begin
            if (up_hit[4]) begin
                sel_note = up_hit[3:0];
            end else if (dn_hit[4]) begin
                sel_note = dn_hit[3:0];
                sel_dir  = 1'b1;
            end
        end else begin
            if (dn_hit[4]) begin
                sel_note = dn_hit[3:0];
            end else if (up_hit[4]) begin
                sel_note = up_hit[3:0];
                sel_dir  = 1'b0;
            end
        end
`else
        sel_note = up_hit[4] ? up_hit[3:0] : lowest_held(held);
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        note_d     = note_q;
        octave_d   = octave_q;
        valid_d    = valid_q;
        step_d     = 1'b0;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        start      = 1'b0;
        start_note = sel_note;
`ifdef ARP_PINGPONG_EN
        dir_d      = dir_q;
`endif
        case (state_q)
            IDLE: begin
                note_d  = SILENT;
                valid_d = 1'b0;
                cnt_d   = '0;
                gap_d   = '0;
                if (bus.enable && (key_q != '0)) begin
                    start      = 1'b1;
                    start_note = lowest_held(held);
`ifdef ARP_PINGPONG_EN
                    dir_d      = 1'b0;
`endif
                end
            end
            PLAY: begin
                if (!bus.enable || (key_q == '0)) begin
                    state_d = IDLE;
                    note_d  = SILENT;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q - 1'b1) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        note_d  = SILENT;
                        valid_d = 1'b0;
                        gap_d   = '0;
                    end else begin
                        start = 1'b1;
`ifdef ARP_PINGPONG_EN
                        dir_d = sel_dir;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (!bus.enable || (key_q == '0)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q == GAP_W'(GAP_LAST)) begin
                    start = 1'b1;
`ifdef ARP_PINGPONG_EN
                    dir_d = sel_dir;
`endif
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                note_d  = SILENT;
                valid_d = 1'b0;
            end
        endcase
        if (start) begin
            state_d  = PLAY;
            cur_d    = start_note;
            note_d   = start_note;
            valid_d  = 1'b1;
            step_d   = 1'b1;
            octave_d = bus.octave_in & 4'h7;
            dwell_d  = dwell_eff;
            cnt_d    = '0;
        end
    end

    // State, key input stage and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            cur_q    <= '0;
            note_q   <= SILENT;
            octave_q <= '0;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
`ifdef ARP_PINGPONG_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            key_q    <= bus.keys;
            cur_q    <= cur_d;
            note_q   <= note_d;
            octave_q <= octave_d;
            valid_q  <= valid_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
`ifdef ARP_PINGPONG_EN
            dir_q    <= dir_d;
`endif
        end
    end

    assign bus.note       = note_q;
    assign bus.octave     = octave_q;
    assign bus.note_valid = valid_q;
    assign bus.step       = step_q;
endmodule

// File: tb/tb_arp_scheduler.sv
// Directed bench for arp_scheduler: one instance without gap, one with a 2-cycle gap,
// both fed the same inputs.
module tb_arp_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef ARP_PINGPONG_EN
    localparam int CHORD_LEN = 4;
`else
    localparam int CHORD_LEN = 3;
`endif
    logic [3:0] chord_seq [4];

    always #5 clk = ~clk;

    arp_if #(.DWELL_W(20)) bus ();
    arp_if #(.DWELL_W(20)) bus_g ();

    assign bus_g.keys      = bus.keys;
    assign bus_g.octave_in = bus.octave_in;
    assign bus_g.enable    = bus.enable;
    assign bus_g.dwell     = bus.dwell;

    arp_scheduler #(.DWELL_W(20), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    arp_scheduler #(.DWELL_W(20), .GAP_CYCLES(2)) dut_gap (
        .clk(clk), .rst_n(rst_n), .bus(bus_g)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        bus.keys = 12'h000;
        tick(); tick(); tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.keys = 12'h800; bus.enable = 1'b1; bus.dwell = 20'd1; bus.octave_in = 4'd5;
        tick(); tick();
        vectors++;
        if (bus.note !== 4'hF) begin miscompares++; $display("FAIL reset_note: got %0h expected f", bus.note); end
        vectors++;
        if (bus.octave !== 4'h0) begin miscompares++; $display("FAIL reset_octave: got %0h expected 0", bus.octave); end
        vectors++;
        if (bus.note_valid !== 1'b0 || bus.step !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got valid=%b step=%b expected 0 0", bus.note_valid, bus.step);
        end
        vectors++;
        if (bus_g.note !== 4'hF || bus_g.note_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_gap_dut: got note=%0h valid=%b expected f 0", bus_g.note, bus_g.note_valid);
        end
        bus.keys = 12'h000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_key;
        logic exp_step;
        go_idle();
        bus.octave_in = 4'd4; bus.dwell = 20'd4; bus.enable = 1'b1; bus.keys = 12'h800;
        tick();
        vectors++;
        if (bus.note !== 4'hF || bus.note_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_latency: got note=%0h valid=%b expected f 0", bus.note, bus.note_valid);
        end
        tick();
        for (int c = 0; c < 13; c++) begin
            exp_step = (c < 8) ? (c % 4 == 0) : (c % 2 == 0);
            vectors++;
            if (bus.note !== 4'd0 || bus.octave !== 4'd4 || bus.note_valid !== 1'b1 || bus.step !== exp_step) begin
                miscompares++;
                $display("FAIL single_c%0d: got note=%0h oct=%0h valid=%b step=%b expected 0 4 1 %b",
                         c, bus.note, bus.octave, bus.note_valid, bus.step, exp_step);
            end
            if (c == 5) bus.dwell = 20'd2;
            tick();
        end
    endtask

    task automatic test_chord;
        logic [3:0] exp_note, exp_oct, g_note;
        logic       exp_step, g_step, g_valid;
        int         ph;
        chord_seq = '{4'd0, 4'd4, 4'd7, 4'd4};
        go_idle();
        bus.octave_in = 4'd4; bus.dwell = 20'd3; bus.enable = 1'b1; bus.keys = 12'h890;
        tick(); tick();
        for (int c = 0; c < 20; c++) begin
            exp_note = chord_seq[(c / 3) % CHORD_LEN];
            exp_step = (c % 3 == 0);
            exp_oct  = (c < 3) ? 4'd4 : 4'd3;
            vectors++;
            if (bus.note !== exp_note || bus.step !== exp_step || bus.octave !== exp_oct || bus.note_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL chord_c%0d: got note=%0h step=%b oct=%0h valid=%b expected %0h %b %0h 1",
                         c, bus.note, bus.step, bus.octave, bus.note_valid, exp_note, exp_step, exp_oct);
            end
            ph      = c % 5;
            g_note  = (ph < 3) ? chord_seq[(c / 5) % CHORD_LEN] : 4'hF;
            g_valid = (ph < 3);
            g_step  = (ph == 0);
            vectors++;
            if (bus_g.note !== g_note || bus_g.note_valid !== g_valid || bus_g.step !== g_step) begin
                miscompares++;
                $display("FAIL gap_c%0d: got note=%0h valid=%b step=%b expected %0h %b %b",
                         c, bus_g.note, bus_g.note_valid, bus_g.step, g_note, g_valid, g_step);
            end
            if (c == 1) bus.octave_in = 4'hB;
            tick();
        end
    endtask

    task automatic test_release_all;
        go_idle();
        bus.octave_in = 4'd2; bus.dwell = 20'd3; bus.enable = 1'b1; bus.keys = 12'h890;
        tick(); tick();
        bus.keys = 12'h000;
        tick(); tick();
        vectors++;
        if (bus.note !== 4'hF || bus.note_valid !== 1'b0 || bus.step !== 1'b0) begin
            miscompares++; $display("FAIL release_silence: got note=%0h valid=%b step=%b expected f 0 0",
                                    bus.note, bus.note_valid, bus.step);
        end
        bus.keys = 12'h200;
        tick();
        vectors++;
        if (bus.note !== 4'hF) begin miscompares++; $display("FAIL restart_latency: got %0h expected f", bus.note); end
        tick();
        vectors++;
        if (bus.note !== 4'd2 || bus.step !== 1'b1 || bus.note_valid !== 1'b1 || bus.octave !== 4'd2) begin
            miscompares++; $display("FAIL restart_d: got note=%0h step=%b valid=%b oct=%0h expected 2 1 1 2",
                                    bus.note, bus.step, bus.note_valid, bus.octave);
        end
    endtask

    task automatic test_release_current;
        logic [3:0] exp_note;
        go_idle();
        bus.dwell = 20'd3; bus.enable = 1'b1; bus.keys = 12'h890;
        tick(); tick();
        for (int c = 0; c < 12; c++) begin
            exp_note = (c < 3) ? 4'd0 : (c < 6) ? 4'd4 : (c < 9) ? 4'd7 : 4'd4;
            vectors++;
            if (bus.note !== exp_note) begin
                miscompares++; $display("FAIL release_cur_c%0d: got %0h expected %0h", c, bus.note, exp_note);
            end
            if (c == 1) bus.keys = 12'h090;
            tick();
        end
    endtask

    task automatic test_dwell_zero;
        logic [3:0] exp_note;
        go_idle();
        bus.octave_in = 4'd6; bus.dwell = 20'd0; bus.enable = 1'b1; bus.keys = 12'hA00;
        tick(); tick();
        for (int c = 0; c < 6; c++) begin
            exp_note = (c % 2 == 1) ? 4'd2 : 4'd0;
            vectors++;
            if (bus.note !== exp_note || bus.step !== 1'b1) begin
                miscompares++; $display("FAIL dwell0_c%0d: got note=%0h step=%b expected %0h 1",
                                        c, bus.note, bus.step, exp_note);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (bus.note !== 4'hF || bus.octave !== 4'd0 || bus.note_valid !== 1'b0 || bus.step !== 1'b0) begin
            miscompares++; $display("FAIL midnote_reset: got note=%0h oct=%0h valid=%b step=%b expected f 0 0 0",
                                    bus.note, bus.octave, bus.note_valid, bus.step);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_enable;
        go_idle();
        bus.octave_in = 4'd1; bus.dwell = 20'd3; bus.enable = 1'b1; bus.keys = 12'h890;
        tick(); tick(); tick();
        bus.enable = 1'b0;
        tick();
        vectors++;
        if (bus.note !== 4'hF || bus.note_valid !== 1'b0) begin
            miscompares++; $display("FAIL disable: got note=%0h valid=%b expected f 0", bus.note, bus.note_valid);
        end
        bus.enable = 1'b1;
        tick();
        vectors++;
        if (bus.note !== 4'd0 || bus.step !== 1'b1 || bus.note_valid !== 1'b1) begin
            miscompares++; $display("FAIL reenable: got note=%0h step=%b valid=%b expected 0 1 1",
                                    bus.note, bus.step, bus.note_valid);
        end
        tick(); tick(); tick();
        vectors++;
        if (bus.note !== 4'd4 || bus.step !== 1'b1) begin
            miscompares++; $display("FAIL reenable_next: got note=%0h step=%b expected 4 1", bus.note, bus.step);
        end
    endtask

    initial begin
        bus.keys = 12'h000; bus.octave_in = 4'd0; bus.enable = 1'b0; bus.dwell = 20'd0;
        rst_n = 1'b0;
        test_reset();
        test_single_key();
        test_chord();
        test_release_all();
        test_release_current();
        test_dwell_zero();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
